// File: rtl/nfca_rx_ask_det.sv
// nfca_rx_ask_det
// ASK demodulator front end for the NFC-A receiver. It takes strobed ADC
// samples and runs them through a three-stage pipeline:
//   1. capture of the raw sample
//   2. moving average over the last 2^LPF_SHIFT samples
//   3. envelope tracking, mid-level threshold with hysteresis, and the
//      pause/carrier decision
// The first 2^LPF_SHIFT samples after reset only fill the averaging
// window. No decisions are made during that time.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   adc_data_en  one-cycle strobe, adc_data valid
//   adc_data     unsigned ADC sample
//   rx_ask_en    one-cycle pulse, rx_ask updated
//   rx_ask       1 = carrier pause, 0 = carrier present
//   rx_lpf_data  current moving-average value
//   rx_raw_data  last captured raw sample
module nfca_rx_ask_det #(
    parameter int ADC_W           = 12,
    parameter int LPF_SHIFT       = 3,
    parameter int HYST            = 16,
    parameter int ENV_DECAY_SHIFT = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             adc_data_en,
    input  logic [ADC_W-1:0] adc_data,
    output logic             rx_ask_en,
    output logic             rx_ask,
    output logic [ADC_W-1:0] rx_lpf_data,
    output logic [ADC_W-1:0] rx_raw_data
);

    localparam int DEPTH = 1 << LPF_SHIFT;
    localparam int SUM_W = ADC_W + LPF_SHIFT;
    localparam int TW    = ADC_W + 2;
    localparam logic [TW-1:0] HYST_T  = TW'(HYST);
    localparam logic [TW-1:0] HYST2_T = TW'(2 * HYST);
    localparam logic [TW-1:0] MAX_T   = TW'((1 << ADC_W) - 1);

    // stage 1: raw capture
    logic v1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1          <= 1'b0;
            rx_raw_data <= '0;
        end else begin
            v1 <= adc_data_en;
            if (adc_data_en)
                rx_raw_data <= adc_data;
        end
    end

    // stage 2: moving average
    logic [ADC_W-1:0]     buf_mem [DEPTH];
    logic [LPF_SHIFT-1:0] wr_ptr;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_next;
    logic                 v2;

    // The entry being overwritten is the oldest one. The buffer starts
    // all-zero, so the sum always equals the buffer total exactly and
    // fits in SUM_W bits. Any intermediate wrap cancels out.
    assign sum_next = sum + SUM_W'(rx_raw_data) - SUM_W'(buf_mem[wr_ptr]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                buf_mem[i] <= '0;
            wr_ptr      <= '0;
            sum         <= '0;
            rx_lpf_data <= '0;
            v2          <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                buf_mem[wr_ptr] <= rx_raw_data;
                wr_ptr          <= wr_ptr + 1'b1;
                sum             <= sum_next;
                rx_lpf_data     <= sum_next[SUM_W-1:LPF_SHIFT];
            end
        end
    end

    // stage 3: envelope, threshold, decision
    logic [LPF_SHIFT:0] warm_cnt;
    logic               warm_done;
    logic               env_loaded;
    logic [ADC_W-1:0]   env_max, env_min;
    logic [ADC_W-1:0]   max_n, min_n;
    logic [TW-1:0]      thr, lo, hi, hi_raw, span;
    logic               ask_n;

    assign warm_done = (warm_cnt == (LPF_SHIFT+1)'(DEPTH));

    // The envelope is advanced with the current lpf value first, and the
    // threshold is then derived from the advanced envelope. This way the
    // decision and the envelope always refer to the same sample.
    always_comb begin
        max_n = env_max;
        min_n = env_min;
        if (!env_loaded) begin
            max_n = rx_lpf_data;
            min_n = rx_lpf_data;
        end else begin
            if (rx_lpf_data > env_max)
                max_n = rx_lpf_data;
            else
                max_n = env_max - ((env_max - rx_lpf_data) >> ENV_DECAY_SHIFT);
            if (rx_lpf_data < env_min)
                min_n = rx_lpf_data;
            else
                min_n = env_min + ((rx_lpf_data - env_min) >> ENV_DECAY_SHIFT);
        end

        thr    = (TW'(max_n) + TW'(min_n)) >> 1;
        lo     = (thr >= HYST_T) ? thr - HYST_T : '0;
        hi_raw = thr + HYST_T;
        hi     = (hi_raw > MAX_T) ? MAX_T : hi_raw;
        // max_n >= lpf >= min_n always holds, so span cannot go negative.
        span   = TW'(max_n) - TW'(min_n);

        ask_n = rx_ask;
        if (span >= HYST2_T) begin
            if (!rx_ask && (TW'(rx_lpf_data) < lo))
                ask_n = 1'b1;
            else if (rx_ask && (TW'(rx_lpf_data) > hi))
                ask_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            warm_cnt   <= '0;
            env_loaded <= 1'b0;
            env_max    <= '0;
            env_min    <= '0;
            rx_ask     <= 1'b0;
            rx_ask_en  <= 1'b0;
        end else begin
            rx_ask_en <= 1'b0;
            if (v2) begin
                if (!warm_done) begin
                    warm_cnt <= warm_cnt + 1'b1;
                end else begin
                    rx_ask_en  <= 1'b1;
                    env_loaded <= 1'b1;
                    env_max    <= max_n;
                    env_min    <= min_n;
                    rx_ask     <= ask_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_nfca_rx_ask_det.sv
// Testbench for nfca_rx_ask_det: a directed vector table plus sequences
// for warm-up, back-to-back strobes, mid-stream reset, square wave,
// noise and full-scale input.
module tb_nfca_rx_ask_det;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        adc_data_en = 1'b0;
    logic [11:0] adc_data = '0;
    logic        rx_ask_en;
    logic        rx_ask;
    logic [11:0] rx_lpf_data;
    logic [11:0] rx_raw_data;

    nfca_rx_ask_det dut (
        .clk         (clk),
        .rstn        (rstn),
        .adc_data_en (adc_data_en),
        .adc_data    (adc_data),
        .rx_ask_en   (rx_ask_en),
        .rx_ask      (rx_ask),
        .rx_lpf_data (rx_lpf_data),
        .rx_raw_data (rx_raw_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference moving average: plain sum over the last 8 samples
    int hist[$];
    int n_samp = 0;
    bit mon_on = 1'b0;
    int exp_raw_map [int];
    int exp_lpf_map [int];
    bit exp_en_map  [int];
    int en_cnt = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_raw_map.exists(cyc)) begin
                check("raw_latency", int'(rx_raw_data), exp_raw_map[cyc]);
                exp_raw_map.delete(cyc);
            end
            if (exp_lpf_map.exists(cyc)) begin
                check("lpf_model", int'(rx_lpf_data), exp_lpf_map[cyc]);
                exp_lpf_map.delete(cyc);
            end
            if (rx_ask_en || exp_en_map.exists(cyc)) begin
                check("ask_en_timing", int'(rx_ask_en), int'(exp_en_map.exists(cyc)));
                exp_en_map.delete(cyc);
            end
            if (rx_ask_en)
                en_cnt++;
        end
    end

    task automatic strobe(input int d);
        int c;
        int s;
        @(negedge clk);
        adc_data_en = 1'b1;
        adc_data    = 12'(d);
        c = cyc;
        hist.push_back(d);
        if (hist.size() > 8)
            void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        n_samp++;
        if (mon_on) begin
            exp_raw_map[c+1] = d;
            exp_lpf_map[c+2] = s / 8;
            if (n_samp > 8)
                exp_en_map[c+3] = 1'b1;
        end
        @(posedge clk);
        #1 adc_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input bit chk);
        @(negedge clk);
        #2 rstn = 1'b0;
        adc_data_en = 1'b0;
        exp_raw_map.delete();
        exp_lpf_map.delete();
        exp_en_map.delete();
        hist.delete();
        n_samp = 0;
        #1;
        if (chk) begin
            check("rst_async_raw", int'(rx_raw_data), 0);
            check("rst_async_lpf", int'(rx_lpf_data), 0);
            check("rst_async_ask", int'(rx_ask), 0);
            check("rst_async_en",  int'(rx_ask_en), 0);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        int data;
        int lpf;
        bit en;
        bit ask;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int prev_ask, toggles, first_hit, target, changes;

        // data, expected lpf, expected ask_en pulse, expected rx_ask
        tbl[0]  = '{800,   100, 1'b0, 1'b0};
        tbl[1]  = '{800,   200, 1'b0, 1'b0};
        tbl[2]  = '{800,   300, 1'b0, 1'b0};
        tbl[3]  = '{800,   400, 1'b0, 1'b0};
        tbl[4]  = '{800,   500, 1'b0, 1'b0};
        tbl[5]  = '{800,   600, 1'b0, 1'b0};
        tbl[6]  = '{800,   700, 1'b0, 1'b0};
        tbl[7]  = '{800,   800, 1'b0, 1'b0};
        tbl[8]  = '{800,   800, 1'b1, 1'b0};
        tbl[9]  = '{4000, 1200, 1'b1, 1'b0};
        tbl[10] = '{0,    1100, 1'b1, 1'b0};
        tbl[11] = '{0,    1000, 1'b1, 1'b0};
        tbl[12] = '{0,     900, 1'b1, 1'b1};
        tbl[13] = '{0,     800, 1'b1, 1'b1};
        tbl[14] = '{4095, 1211, 1'b1, 1'b0};
        tbl[15] = '{4095, 1623, 1'b1, 1'b0};

        // power-on reset values
        #3;
        check("por_raw", int'(rx_raw_data), 0);
        check("por_lpf", int'(rx_lpf_data), 0);
        check("por_ask", int'(rx_ask), 0);
        check("por_en",  int'(rx_ask_en), 0);
        idle(2);
        rstn = 1'b1;

        // directed table, per-stage latency checks
        for (int k = 0; k < 16; k++) begin
            strobe(tbl[k].data);
            @(negedge clk);
            check("tbl_raw", int'(rx_raw_data), tbl[k].data);
            @(negedge clk);
            check("tbl_lpf", int'(rx_lpf_data), tbl[k].lpf);
            check("tbl_en_early", int'(rx_ask_en), 0);
            @(negedge clk);
            check("tbl_en", int'(rx_ask_en), int'(tbl[k].en));
            check("tbl_ask", int'(rx_ask), int'(tbl[k].ask));
            @(negedge clk);
            check("tbl_en_width", int'(rx_ask_en), 0);
            idle(2);
        end
        idle(3);
        check("idle_lpf_hold", int'(rx_lpf_data), 1623);
        check("idle_raw_hold", int'(rx_raw_data), 4095);

        // constant 2048, one sample every 49 clocks
        apply_reset(1'b1);
        mon_on = 1'b1;
        en_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            strobe(2048);
            idle(48);
        end
        check("const_lpf", int'(rx_lpf_data), 2048);
        check("const_ask", int'(rx_ask), 0);
        check("const_pulses", en_cnt, 4);

        // 20 back-to-back strobes
        en_cnt = 0;
        for (int k = 0; k < 20; k++)
            strobe(int'($urandom_range(0, 4095)));
        idle(6);
        check("b2b_pulses", en_cnt, 20);

        // reset in the middle of a stream
        apply_reset(1'b0);
        for (int k = 0; k < 40; k++) begin
            strobe(1000 + k);
            idle(2);
        end
        strobe(1500);
        apply_reset(1'b1);
        en_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            strobe(300 + k);
            idle(3);
        end
        idle(4);
        check("midrst_no_pulse_warmup", en_cnt, 0);
        for (int k = 0; k < 2; k++) begin
            strobe(310);
            idle(3);
        end
        idle(4);
        check("midrst_pulses_after", en_cnt, 2);

        // square wave 3000/500, 64-sample half period
        apply_reset(1'b0);
        prev_ask = 0;
        for (int p = 0; p < 5; p++) begin
            for (int h = 0; h < 2; h++) begin
                toggles   = 0;
                first_hit = -1;
                target    = h;
                for (int k = 0; k < 64; k++) begin
                    strobe(h ? 500 : 3000);
                    idle(3);
                    if (int'(rx_ask) != prev_ask)
                        toggles++;
                    if (int'(rx_ask) == target && first_hit < 0)
                        first_hit = k;
                    prev_ask = int'(rx_ask);
                end
                if (p >= 2) begin
                    check("sq_edge_within_6", int'(first_hit >= 0 && first_hit <= 5), 1);
                    check("sq_toggles", toggles, 1);
                end
            end
        end

        // 2048 +/- 10 noise
        apply_reset(1'b0);
        en_cnt  = 0;
        changes = 0;
        for (int k = 0; k < 100; k++) begin
            strobe(2038 + int'($urandom_range(0, 20)));
            idle(3);
            if (rx_ask != 1'b0)
                changes++;
        end
        idle(2);
        check("noise_ask_changes", changes, 0);
        check("noise_pulses", en_cnt, 92);

        // alternating full scale, then full-scale steps
        apply_reset(1'b0);
        for (int k = 0; k < 24; k++) begin
            strobe((k % 2 == 0) ? 4095 : 0);
            idle(3);
        end
        check("alt_lpf", int'(rx_lpf_data), 2047);
        check("alt_ask", int'(rx_ask), 0);
        for (int k = 0; k < 16; k++) begin
            strobe(4095);
            idle(3);
        end
        check("fs_high_lpf", int'(rx_lpf_data), 4095);
        check("fs_high_ask", int'(rx_ask), 0);
        for (int k = 0; k < 16; k++) begin
            strobe(0);
            idle(3);
        end
        check("fs_low_lpf", int'(rx_lpf_data), 0);
        check("fs_low_ask", int'(rx_ask), 1);
        for (int k = 0; k < 16; k++) begin
            strobe(4095);
            idle(3);
        end
        check("fs_recover_ask", int'(rx_ask), 0);

        mon_on = 1'b0;
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
